mem_arbiter: RTL and testbench

Shared-memory arbiter and burst sequencer between the instruction-cache refill path (fetch side) and the data cache (execution side) of the CPU pipeline. It arbitrates round-robin between the two cache requesters, owns a single line-burst memory port, and sequences a fixed-length burst of `LINE_BEATS` beats. Read data is routed back to the burst owner, and write data is pulled from it beat by beat. It sits below `fetch_top`'s I-cache and the execution unit's D-cache, in front of the external memory interface.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Round-robin arbiter and line-burst sequencer that sits between the I-cache
// refill path, the D-cache, and a single external memory port. One requester
// owns the port for a fixed LINE_BEATS-beat burst. Read beats are routed to
// the owner, and write beats are pulled from the D-cache by beat index.
//
// Parameters
//   ADDR        byte-address width
//   DATA        beat data width
//   LINE_BEATS  beats per cache line (power of two, >= 2)
//
// Ports
//   clk, reset_                 clock, asynchronous active-low reset
//   ic_req/ic_addr              I-cache line read request (held until ic_done)
//   ic_rvalid/ic_rdata/ic_done  I-cache read beats and end-of-burst pulse
//   dc_req/dc_we/dc_addr        D-cache line request (fill or write-back)
//   dc_wdata/dc_wbeat           write data for the beat index presented
//   dc_rvalid/dc_rdata/dc_done  D-cache read beats and end-of-burst pulse
//   mem_req/mem_we/mem_addr     burst request, direction, line-aligned base
//   mem_wdata                   write beat data
//   mem_ack/mem_rdata           beat accepted / read beat valid, read data
module mem_arbiter #(
    parameter int ADDR       = 32,
    parameter int DATA       = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          reset_,
    input  logic                          ic_req,
    input  logic [ADDR-1:0]               ic_addr,
    output logic                          ic_rvalid,
    output logic [DATA-1:0]               ic_rdata,
    output logic                          ic_done,
    input  logic                          dc_req,
    input  logic                          dc_we,
    input  logic [ADDR-1:0]               dc_addr,
    input  logic [DATA-1:0]               dc_wdata,
    output logic [$clog2(LINE_BEATS)-1:0] dc_wbeat,
    output logic                          dc_rvalid,
    output logic [DATA-1:0]               dc_rdata,
    output logic                          dc_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR-1:0]               mem_addr,
    output logic [DATA-1:0]               mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA-1:0]               mem_rdata
);

    localparam int BEAT_W = $clog2(LINE_BEATS);
    // Byte offset bits within one line; cleared to form the burst base address.
    localparam logic [ADDR-1:0] OFFSET_MASK = ADDR'((LINE_BEATS * DATA / 8) - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_reg;
    logic                owner_dc_reg;   // 1 = D-cache owns the current burst
    logic                last_dc_reg;    // owner of the most recent grant
    logic [ADDR-1:0]     addr_reg;
    logic                we_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic                mem_req_reg;

    logic                in_burst;
    logic                grant_dc;
    logic                last_beat;
    logic                ack_ic;
    logic                ack_dc;

    assign in_burst  = (state_reg == BURST);
    assign last_beat = (beat_reg == BEAT_W'(LINE_BEATS - 1));

    // On a tie the requester that did not win last time takes the port.
    assign grant_dc  = dc_req & (~ic_req | ~last_dc_reg);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg    <= IDLE;
            owner_dc_reg <= 1'b0;
            last_dc_reg  <= 1'b1;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            beat_reg     <= '0;
            mem_req_reg  <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (ic_req | dc_req) begin
                state_reg    <= BURST;
                mem_req_reg  <= 1'b1;
                owner_dc_reg <= grant_dc;
                last_dc_reg  <= grant_dc;
                addr_reg     <= (grant_dc ? dc_addr : ic_addr) & ~OFFSET_MASK;
                we_reg       <= grant_dc & dc_we;
                beat_reg     <= '0;
            end
        end else if (mem_ack) begin
            if (last_beat) begin
                // Clear the port fields so an idle port presents all zeros.
                state_reg   <= IDLE;
                mem_req_reg <= 1'b0;
                addr_reg    <= '0;
                we_reg      <= 1'b0;
                beat_reg    <= '0;
            end else begin
                beat_reg <= beat_reg + BEAT_W'(1);
            end
        end
    end

    // Beat strobes are combinational from mem_ack; acks seen in IDLE are dropped.
    assign ack_ic    = mem_ack & in_burst & ~owner_dc_reg;
    assign ack_dc    = mem_ack & in_burst & owner_dc_reg;

    assign ic_rvalid = ack_ic;
    assign ic_rdata  = ack_ic ? mem_rdata : '0;
    assign ic_done   = ack_ic & last_beat;

    assign dc_rvalid = ack_dc & ~we_reg;
    assign dc_rdata  = (ack_dc & ~we_reg) ? mem_rdata : '0;
    assign dc_done   = ack_dc & last_beat;

    assign dc_wbeat  = (in_burst & owner_dc_reg) ? beat_reg : '0;
    assign mem_wdata = (in_burst & owner_dc_reg & we_reg) ? dc_wdata : '0;

    assign mem_req   = mem_req_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven single bursts, hand-written
// corner sequences (stalls, ties, spurious events, async reset) and a random
// phase checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR       = 32;
    localparam int DATA       = 32;
    localparam int LINE_BEATS = 4;
    localparam int LINE_BYTES = LINE_BEATS * DATA / 8;

    logic            clk;
    logic            reset_;
    logic            ic_req;
    logic [31:0]     ic_addr;
    logic            ic_rvalid;
    logic [31:0]     ic_rdata;
    logic            ic_done;
    logic            dc_req;
    logic            dc_we;
    logic [31:0]     dc_addr;
    logic [31:0]     dc_wdata;
    logic [1:0]      dc_wbeat;
    logic            dc_rvalid;
    logic [31:0]     dc_rdata;
    logic            dc_done;
    logic            mem_req;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic            mem_ack;
    logic [31:0]     mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR(ADDR), .DATA(DATA), .LINE_BEATS(LINE_BEATS)) dut (
        .clk(clk), .reset_(reset_),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wbeat(dc_wbeat), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
        .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_ = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_ = 1'b1;
    endtask

    // Start a burst, give it two acks, then pull reset between clock edges.
    task automatic reset_mid(input logic use_dc);
        @(negedge clk);
        ic_req = ~use_dc; dc_req = use_dc; dc_we = 1'b1;
        dc_addr = 32'h3008; ic_addr = 32'h6004; mem_ack = 1'b0;
        @(negedge clk);
        ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_pre_req", mem_req, 1);
        chk("rst_pre_wbeat", dc_wbeat, use_dc ? 2 : 0);
        reset_ = 1'b0;
        #1;
        chk("rst_async_req", mem_req, 0);
        chk("rst_async_wbeat", dc_wbeat, 0);
        chk("rst_async_strobes", {ic_done, dc_done, ic_rvalid, dc_rvalid}, 0);
        chk("rst_async_addr_we", {mem_addr, mem_we}, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        #2 reset_ = 1'b1;
        $display("reset mid-burst (%s owner) abandoned", use_dc ? "DC" : "IC");
    endtask

    typedef struct {
        logic        ic_req;
        logic        dc_req;
        logic        dc_we;
        logic [31:0] ic_addr;
        logic [31:0] dc_addr;
        logic        exp_dc;
        logic        exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[6];

    // Reference model state (transaction level)
    bit          m_busy;
    bit          m_dc;
    bit          m_we;
    bit          m_last_dc;
    int          m_cnt;
    logic [31:0] m_base;

    initial begin
        int n;
        logic ack;
        logic [31:0] ea;

        //           icr   dcr   dwe   ic_addr        dc_addr        dc    we    addr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0,         1'b0, 1'b0, 32'h0000_1230};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_201F, 1'b1, 1'b1, 32'h0000_2010};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hABCD_EF07, 32'h7777_0000, 1'b0, 1'b0, 32'hABCD_EF00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h5555_5555, 1'b1, 1'b1, 32'h5555_5550};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_000F, 1'b1, 1'b0, 32'h0000_0000};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0040, 1'b0, 1'b0, 32'hFFFF_FFF0};

        reset_ = 1'b0; ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = 0; dc_addr = 0;
        dc_wdata = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        chk("reset_state", {mem_req, mem_we, mem_addr, dc_wbeat, ic_done, dc_done}, 0);
        repeat (2) @(negedge clk);
        #2 reset_ = 1'b1;

        // ---------------- table-driven single bursts ----------------
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ic_req = tbl[i].ic_req; dc_req = tbl[i].dc_req; dc_we = tbl[i].dc_we;
            ic_addr = tbl[i].ic_addr; dc_addr = tbl[i].dc_addr; mem_ack = 0;
            #2 chk("tbl_latency", mem_req, 0);
            @(negedge clk);
            ic_req = 0; dc_req = 0;
            #2;
            chk("tbl_req", mem_req, 1);
            chk("tbl_we", mem_we, tbl[i].exp_we);
            chk("tbl_addr", mem_addr, tbl[i].exp_addr);
            for (int b = 0; b < LINE_BEATS; b++) begin
                @(negedge clk);
                mem_ack = 1; mem_rdata = $urandom; dc_wdata = $urandom;
                #2;
                chk("tbl_ic_rvalid", ic_rvalid, !tbl[i].exp_dc);
                chk("tbl_dc_rvalid", dc_rvalid, tbl[i].exp_dc && !tbl[i].exp_we);
                chk("tbl_ic_done", ic_done, !tbl[i].exp_dc && b == LINE_BEATS - 1);
                chk("tbl_dc_done", dc_done, tbl[i].exp_dc && b == LINE_BEATS - 1);
                chk("tbl_wbeat", dc_wbeat, tbl[i].exp_dc ? b : 0);
            end
            @(negedge clk);
            mem_ack = 0;
            #2 chk("tbl_end_idle", mem_req, 0);
            $display("vector %0d: owner=%s we=%0d addr=0x%08h", i,
                     tbl[i].exp_dc ? "DC" : "IC", tbl[i].exp_we, tbl[i].exp_addr);
        end

        // ---------------- IC read alone ----------------
        @(negedge clk);
        ic_req = 1; ic_addr = 32'h1234;
        #2 chk("icr_latency", mem_req, 0);
        @(negedge clk);
        #2;
        chk("icr_addr", mem_addr, 32'h1230);
        chk("icr_we", {mem_req, mem_we}, 2'b10);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            mem_ack = 1; mem_rdata = 32'hA0 + b;
            #2;
            chk("icr_rvalid", ic_rvalid, 1);
            chk("icr_rdata", ic_rdata, 32'hA0 + b);
            chk("icr_done", ic_done, b == 3);
        end
        @(negedge clk);
        ic_req = 0; mem_ack = 0;
        #2 chk("icr_end_idle", mem_req, 0);
        $display("IC read 0x1234 -> 4 beats");

        // ---------------- DC write-back with stalls ----------------
        @(negedge clk);
        dc_req = 1; dc_we = 1; dc_addr = 32'h8000_0044;
        @(negedge clk);
        #2;
        chk("dcw_addr", mem_addr, 32'h8000_0040);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) begin dc_we = 0; dc_addr = 32'h0; end
            ack = (c == 1 || c == 4 || c == 5 || c == 9);
            mem_ack = ack; dc_wdata = $urandom;
            #2;
            chk("dcw_req_we", {mem_req, mem_we}, 2'b11);
            chk("dcw_wbeat", dc_wbeat, n);
            chk("dcw_wdata", mem_wdata, dc_wdata);
            chk("dcw_rvalid", dc_rvalid, 0);
            chk("dcw_done", dc_done, ack && n == 3);
            if (ack) n++;
        end
        @(negedge clk);
        dc_req = 0; mem_ack = 0;
        #2;
        chk("dcw_end_idle", mem_req, 0);
        chk("dcw_end_wbeat", dc_wbeat, 0);
        $display("DC write-back 0x80000044 with stalls -> 4 beats");

        // ---------------- simultaneous requests ----------------
        @(negedge clk);
        ic_req = 1; dc_req = 1; dc_we = 0; ic_addr = 32'h1000; dc_addr = 32'h2000;
        #2 chk("tie_latency", mem_req, 0);
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            mem_ack = 0;
            #2;
            chk("tie_req", mem_req, 1);
            chk("tie_addr", mem_addr, (g % 2) ? 32'h2000 : 32'h1000);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                mem_ack = 1;
                #2;
                chk("tie_ic_done", ic_done, (g % 2 == 0) && b == 3);
                chk("tie_dc_done", dc_done, (g % 2 == 1) && b == 3);
            end
            @(negedge clk);
            mem_ack = 0;
            if (g == 3) begin ic_req = 0; dc_req = 0; end
            #2 chk("tie_gap", mem_req, 0);
            $display("tie grant %0d -> %s", g, (g % 2) ? "DC" : "IC");
        end

        // ---------------- spurious events ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack = 1;
            #2 chk("spur_idle_ack", {mem_req, ic_rvalid, dc_rvalid, ic_done, dc_done}, 0);
        end
        @(negedge clk);
        ic_req = 1; ic_addr = 32'h4448;
        #2 chk("spur_ack_grant_cycle", ic_rvalid, 0);
        @(negedge clk);
        ic_req = 0; ic_addr = 32'h9999; mem_ack = 0;
        #2 chk("spur_addr0", mem_addr, 32'h4440);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ack = (c != 1 && c != 4);
            mem_ack = ack;
            #2;
            chk("spur_req", mem_req, 1);
            chk("spur_addr", mem_addr, 32'h4440);
            chk("spur_done", ic_done, ack && n == 3);
            if (ack) n++;
        end
        @(negedge clk);
        mem_ack = 0;
        #2 chk("spur_end_idle", mem_req, 0);
        $display("spurious ack / dropped request burst complete");

        // ---------------- reset mid-burst ----------------
        reset_mid(1'b1);
        reset_mid(1'b0);
        @(negedge clk);
        ic_req = 1; dc_req = 1; dc_we = 0; ic_addr = 32'h1110; dc_addr = 32'h2220;
        @(negedge clk);
        ic_req = 0; dc_req = 0;
        #2 chk("rst_first_tie_ic", {mem_req, mem_addr}, {1'b1, 32'h1110});
        $display("post-reset tie -> IC");

        // ---------------- random vs reference model ----------------
        do_reset();
        m_busy = 0; m_last_dc = 1; m_cnt = 0; m_dc = 0; m_we = 0; m_base = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            ic_req = ($urandom_range(0, 3) == 0);
            dc_req = ($urandom_range(0, 3) == 0);
            dc_we = $urandom_range(0, 1);
            ic_addr = $urandom; dc_addr = $urandom;
            dc_wdata = $urandom; mem_rdata = $urandom;
            mem_ack = $urandom_range(0, 1);
            #2;
            chk("rnd_req", mem_req, m_busy);
            chk("rnd_we", mem_we, m_busy && m_we);
            chk("rnd_addr", mem_addr, m_busy ? m_base : 32'h0);
            chk("rnd_ic", {ic_rvalid, ic_done, ic_rdata},
                {m_busy && !m_dc && mem_ack,
                 m_busy && !m_dc && mem_ack && m_cnt == LINE_BEATS - 1,
                 (m_busy && !m_dc && mem_ack) ? mem_rdata : 32'h0});
            chk("rnd_dc", {dc_rvalid, dc_done, dc_rdata},
                {m_busy && m_dc && !m_we && mem_ack,
                 m_busy && m_dc && mem_ack && m_cnt == LINE_BEATS - 1,
                 (m_busy && m_dc && !m_we && mem_ack) ? mem_rdata : 32'h0});
            chk("rnd_wbeat", dc_wbeat, (m_busy && m_dc) ? m_cnt : 0);
            chk("rnd_wdata", mem_wdata, (m_busy && m_dc && m_we) ? dc_wdata : 32'h0);
            if (!m_busy) begin
                if (ic_req || dc_req) begin
                    m_dc = dc_req && !(ic_req && m_last_dc);
                    m_last_dc = m_dc;
                    ea = m_dc ? dc_addr : ic_addr;
                    m_base = ea - (ea % LINE_BYTES);
                    m_we = m_dc && dc_we;
                    m_cnt = 0;
                    m_busy = 1;
                end
            end else if (mem_ack) begin
                m_cnt++;
                if (m_cnt == LINE_BEATS) begin
                    m_busy = 0;
                    $display("random burst done: owner=%s we=%0d base=0x%08h",
                             m_dc ? "DC" : "IC", m_we, m_base);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
